// File: rtl/cac_fns_pkg.sv
// Shared definitions for the 6-TSV Fibonacci-numeral-system (FNS) link:
// codeword width, Fibonacci weights, decoder FSM states and the
// forbidden-transition check used by both encoder and decoder.
// No ports (package).
package cac_fns_pkg;

  localparam int unsigned FNS_N_TSV = 6;
  localparam int unsigned FNS_WT_W  = 4;

  // Weight of codeword bit k, k = 0..5.
  localparam logic [FNS_WT_W-1:0] W [0:5] = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } fns_state_e;

  // An odd line held at 0 next to an even line at 1 is a forbidden pattern.
  function automatic logic fns_is_forbidden(input logic [5:0] w);
    return (!w[1] && (w[0] || w[2])) ||
           (!w[3] && (w[2] || w[4])) ||
           (!w[5] &&  w[4]);
  endfunction

endpackage

// File: rtl/cac_ftf_checker.sv
// Combinational forbidden-transition check on one 6-bit codeword.
// Ports:
//   word    in  6  codeword to evaluate
//   fault_c out 1  codeword violates the forbidden-transition rule
module cac_ftf_checker
  import cac_fns_pkg::*;
(
  input  logic [5:0] word,
  output logic       fault_c
);

  assign fault_c = fns_is_forbidden(word);

endmodule

// File: rtl/cac_fns_decoder_6.sv
// Registered, handshaked FNS decoder: captures a 6-bit TSV codeword,
// accumulates its Fibonacci-weighted value MSB first over six cycles,
// flags forbidden patterns and keeps a saturating fault count.
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   tsv, in_valid         codeword input and its valid
//   in_ready              block can accept a codeword
//   dataout, out_fault    decoded value and fault flag
//   out_valid, out_ready  output handshake
//   err_count             saturating count of faulty codewords accepted
module cac_fns_decoder_6 #(
  parameter int unsigned N_TSV  = 6,
  parameter int unsigned DATA_W = 5,
  parameter int unsigned ERR_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_TSV-1:0]  tsv,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] dataout,
  output logic              out_fault,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ERR_W-1:0]  err_count
);

  import cac_fns_pkg::*;

  localparam int unsigned CNT_W = 3;

  fns_state_e        state;
  fns_state_e        state_next;
  logic [N_TSV-1:0]  shreg;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic              fault_r;
  logic              fault_c;
  logic              accept;
  logic              deliver;
  logic              in_ready_next;
  logic              out_valid_next;
  logic              load_out;

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  cac_ftf_checker u_checker (
    .word    (tsv),
    .fault_c (fault_c)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)        state_next = ACCUM;
      ACCUM:   if (cnt == '0)     state_next = DONE;
      DONE:    if (deliver)       state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Next values of the registered handshake outputs; results load on the
  // first DONE cycle, so out_valid trails entry into DONE by one edge.
  always_comb begin
    in_ready_next  = 1'b0;
    out_valid_next = 1'b0;
    load_out       = 1'b0;
    in_ready_next  = (state_next == IDLE);
    if (state == DONE) begin
      out_valid_next = !deliver;
      load_out       = !out_valid;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      dataout   <= '0;
      out_fault <= 1'b0;
      err_count <= '0;
      acc       <= '0;
      cnt       <= '0;
      shreg     <= '0;
      fault_r   <= 1'b0;
    end else begin
      in_ready  <= in_ready_next;
      out_valid <= out_valid_next;
      if (accept) begin
        shreg   <= tsv;
        fault_r <= fault_c;
        acc     <= '0;
        cnt     <= CNT_W'(N_TSV - 1);
        if (fault_c && (err_count != '1)) err_count <= err_count + 1'b1;
      end else if (state == ACCUM) begin
        // MSB of the shift register always pairs with weight W[cnt].
        if (shreg[N_TSV-1]) acc <= acc + DATA_W'(W[cnt]);
        shreg <= shreg << 1;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
      if (load_out) begin
        dataout   <= acc;
        out_fault <= fault_r;
      end
    end
  end

endmodule

// File: tb/tb_cac_fns_decoder_6.sv
// Self-checking bench for cac_fns_decoder_6: directed words, random words
// with random stalls, mid-operation reset and fault-counter saturation,
// all checked against an arithmetic reference model.
module tb_cac_fns_decoder_6;

  logic       clock;
  logic       reset;
  logic [5:0] tsv;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] dataout;
  logic       out_fault;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] err_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_err = 0;

  cac_fns_decoder_6 #(.N_TSV(6), .DATA_W(5), .ERR_W(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .tsv       (tsv),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dataout   (dataout),
    .out_fault (out_fault),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_count (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Fibonacci weight of bit k: 1, 1, 2, 3, 5, 8.
  function automatic int fib_w(input int k);
    int a = 1;
    int b = 1;
    int t;
    for (int i = 0; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int model_value(input logic [5:0] w);
    int s = 0;
    for (int k = 0; k < 6; k++) if (w[k]) s += fib_w(k);
    return s;
  endfunction

  function automatic int model_fault(input logic [5:0] w);
    int f = 0;
    for (int j = 1; j < 6; j += 2) begin
      if (!w[j] && (w[j-1] || ((j < 5) && w[j+1]))) f = 1;
    end
    return f;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sends one word, pulsing in_valid randomly while busy, stalls the
  // result for `stall` cycles and checks latency, value, flag and counter.
  task automatic run_word(input logic [5:0] w, input int stall);
    int lat;
    int exp_d;
    int exp_f;
    exp_d = model_value(w);
    exp_f = model_fault(w);
    if (exp_f != 0 && exp_err < 255) exp_err++;
    check("in_ready_before_accept", 32'(in_ready), 1);
    tsv      = w;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    tsv       = 6'($urandom);
    out_ready = (stall == 0);
    lat = 0;
    do begin
      @(posedge clock);
      #1;
      lat++;
      if (!out_valid) begin
        check("in_ready_busy", 32'(in_ready), 0);
        in_valid = 1'($urandom);
        tsv      = 6'($urandom);
      end
    end while (!out_valid && lat < 20);
    in_valid = 1'b0;
    check("latency", 32'(lat), 7);
    check("dataout", 32'(dataout), 32'(exp_d));
    check("out_fault", 32'(out_fault), 32'(exp_f));
    check("err_count", 32'(err_count), 32'(exp_err));
    for (int i = 0; i < stall; i++) begin
      tsv      = 6'($urandom);
      in_valid = 1'($urandom);
      @(posedge clock);
      #1;
      check("stall_valid", 32'(out_valid), 1);
      check("stall_data", 32'(dataout), 32'(exp_d));
      check("stall_fault", 32'(out_fault), 32'(exp_f));
      check("stall_in_ready", 32'(in_ready), 0);
      check("stall_err", 32'(err_count), 32'(exp_err));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    check("valid_drop", 32'(out_valid), 0);
    check("in_ready_return", 32'(in_ready), 1);
  endtask

  initial begin
    reset     = 1'b1;
    tsv       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_dataout", 32'(dataout), 0);
    check("rst_out_fault", 32'(out_fault), 0);
    check("rst_err_count", 32'(err_count), 0);
    reset = 1'b0;

    // Directed words.
    run_word(6'b101010, 0);
    run_word(6'b010101, 0);
    run_word(6'b111111, 0);
    run_word(6'b000000, 0);
    run_word(6'b000010, 0);
    run_word(6'b011011, 10);

    // Reset during the third ACCUM cycle aborts the word.
    run_word(6'b000001, 0);
    tsv      = 6'b101010;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset   = 1'b0;
    exp_err = 0;
    check("abort_in_ready", 32'(in_ready), 1);
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_err_count", 32'(err_count), 0);
    check("abort_dataout", 32'(dataout), 0);
    repeat (8) @(posedge clock);
    #1;
    check("abort_no_delivery", 32'(out_valid), 0);
    run_word(6'b101010, 0);

    // Random words with random back-pressure.
    for (int n = 0; n < 40; n++) run_word(6'($urandom), int'($urandom_range(0, 3)));

    // Fault counter saturation.
    for (int n = 0; n < 300; n++) run_word(6'b010101, 0);
    check("err_saturated", 32'(err_count), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
